// File: rtl/operand_fetch_stage.sv
// rtl/operand_fetch_stage.sv - ID/EX operand fetch: x0/EX-MEM/WB forwarding, load-use stall, 1-entry output buffer
// Optional feature macro: WB_BYPASS_EN (writeback-to-operand forwarding instead of a writeback stall).
module operand_fetch_stage #(
    parameter int XLEN        = 64,
    parameter int CTRL_W      = 16,
    parameter int STALL_CNT_W = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [XLEN-1:0]        in_pc,
    input  logic [4:0]             in_rs1,
    input  logic [4:0]             in_rs2,
    input  logic                   in_use_rs1,
    input  logic                   in_use_rs2,
    input  logic [4:0]             in_rd,
    input  logic [XLEN-1:0]        in_imm,
    input  logic [CTRL_W-1:0]      in_ctrl,
    input  logic [XLEN-1:0]        rf_rd1,
    input  logic [XLEN-1:0]        rf_rd2,
    input  logic                   exm_valid,
    input  logic                   exm_is_load,
    input  logic [4:0]             exm_rd,
    input  logic [XLEN-1:0]        exm_result,
    input  logic                   wb_we,
    input  logic [4:0]             wb_rd,
    input  logic [XLEN-1:0]        wb_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [XLEN-1:0]        out_pc,
    output logic [4:0]             out_rd,
    output logic [XLEN-1:0]        out_imm,
    output logic [CTRL_W-1:0]      out_ctrl,
    output logic [XLEN-1:0]        out_op1,
    output logic [XLEN-1:0]        out_op2,
    output logic [STALL_CNT_W-1:0] stall_cycles
);

    logic                   valid_q, valid_d;
    logic [XLEN-1:0]        pc_q, imm_q, op1_q, op2_q;
    logic [4:0]             rd_q;
    logic [CTRL_W-1:0]      ctrl_q;
    logic [STALL_CNT_W-1:0] stall_q;
    logic [XLEN-1:0]        op1_d, op2_d;
    logic                   load_hazard, wb_hazard, accept, stall;

    function automatic logic [XLEN-1:0] resolve(
        input logic [4:0]      idx,
        input logic [XLEN-1:0] rf_val,
        input logic            e_valid,
        input logic            e_load,
        input logic [4:0]      e_rd,
        input logic [XLEN-1:0] e_res,
        input logic            w_we,
        input logic [4:0]      w_rd,
        input logic [XLEN-1:0] w_data
    );
        logic [XLEN-1:0] r;
        r = rf_val;
`ifdef WB_BYPASS_EN
        if (w_we && (w_rd == idx)) r = w_data;
`else
        if (w_we && (w_rd == idx) && 1'b0) r = w_data;
`endif
        if (e_valid && !e_load && (e_rd == idx)) r = e_res;
        if (idx == 5'd0) r = '0;
        return r;
    endfunction

    function automatic logic src_match(
        input logic       use_s,
        input logic [4:0] idx,
        input logic       en,
        input logic [4:0] dst
    );
        return use_s && (idx != 5'd0) && en && (dst == idx);
    endfunction

    always_comb begin
        op1_d = resolve(in_rs1, rf_rd1, exm_valid, exm_is_load, exm_rd, exm_result, wb_we, wb_rd, wb_data);
        op2_d = resolve(in_rs2, rf_rd2, exm_valid, exm_is_load, exm_rd, exm_result, wb_we, wb_rd, wb_data);
    end

    assign load_hazard = in_valid &&
        (src_match(in_use_rs1, in_rs1, exm_valid && exm_is_load, exm_rd) ||
         src_match(in_use_rs2, in_rs2, exm_valid && exm_is_load, exm_rd));

`ifdef WB_BYPASS_EN
    assign wb_hazard = 1'b0;
`else
    // The regfile returns the pre-write value in the write cycle, so a same-cycle reader must wait.
    assign wb_hazard = in_valid &&
        (src_match(in_use_rs1, in_rs1, wb_we, wb_rd) ||
         src_match(in_use_rs2, in_rs2, wb_we, wb_rd));
`endif

    assign in_ready = !rst && !flush && !load_hazard && !wb_hazard && (!valid_q || out_ready);
    assign accept   = in_valid && in_ready;
    assign stall    = in_valid && !in_ready && !flush;

    always_comb begin
        valid_d = valid_q;
        if (flush)
            valid_d = 1'b0;
        else if (accept)
            valid_d = 1'b1;
        else if (valid_q && out_ready)
            valid_d = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            pc_q    <= '0;
            rd_q    <= '0;
            imm_q   <= '0;
            ctrl_q  <= '0;
            op1_q   <= '0;
            op2_q   <= '0;
            stall_q <= '0;
        end else begin
            valid_q <= valid_d;
            if (accept && !flush) begin
                pc_q   <= in_pc;
                rd_q   <= in_rd;
                imm_q  <= in_imm;
                ctrl_q <= in_ctrl;
                op1_q  <= op1_d;
                op2_q  <= op2_d;
            end
            if (stall && (stall_q != {STALL_CNT_W{1'b1}}))
                stall_q <= stall_q + STALL_CNT_W'(1);
        end
    end

    assign out_valid    = valid_q;
    assign out_pc       = pc_q;
    assign out_rd       = rd_q;
    assign out_imm      = imm_q;
    assign out_ctrl     = ctrl_q;
    assign out_op1      = op1_q;
    assign out_op2      = op2_q;
    assign stall_cycles = stall_q;

endmodule
